multiplier_trio: RTL and testbench
==================================

Name: multiplier_trio

Overview:
- Signed 32x32 -> 64-bit multiplier block with three independent implementations: radix-2 Booth (sequential), shift-accumulate on magnitudes (sequential), and a combinational partial-product tree.
- Used as the ALU multiply unit and as a cross-checking reference between architectures.
- Sequential engines share one start/done handshake. A match flag reports whether all three products agree.

Parameters:
- WIDTH, 32, operand width in bits (two's complement); products are 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches m/q into both sequential engines.
- m  input  WIDTH  signed multiplicand.
- q  input  WIDTH  signed multiplier.
- booth_product  output  2*WIDTH  Booth engine result, registered.
- shift_product  output  2*WIDTH  shift-accumulate engine result, registered.
- tree_product  output  2*WIDTH  combinational m*q from the tree.
- booth_done  output  1  Booth result valid.
- shift_done  output  1  shift-accumulate result valid.
- done  output  1  booth_done AND shift_done.
- products_match  output  1  1 when done=1 and all three products are equal; 0 otherwise.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both engines go to IDLE.
  - booth_product = 0, shift_product = 0.
  - booth_done = 0, shift_done = 0.
  - rst has priority over start.
- Engine states: IDLE -> RUN -> DONE.
  - Both engines use the same states and the same timing.
  - start=1 sampled in any state (IDLE, RUN or DONE) loads the operands, clears done, clears the 5-bit iteration counter, and enters RUN. A start during RUN aborts and restarts the operation.
- RUN lasts exactly WIDTH=32 edges.
  - On the 32nd edge after the start edge, the engine writes its product and enters DONE with done=1.
  - Result: done is low throughout the start cycle and the next 31 cycles, and rises 32 cycles after start was sampled.
- DONE: product and done hold until the next start or rst. m/q changes are ignored while the engine is in DONE.
- Booth engine (radix-2):
  - Accumulator is WIDTH+1 bits, so that -2^(WIDTH-1) is handled exactly.
  - Each iteration inspects {Q[0], Q_-1}:
    - 01 -> A += M
    - 10 -> A -= M
    - 00 and 11 -> no add
  - Then arithmetic-shift {A, Q, Q_-1} right by 1.
  - Product = {A[WIDTH-1:0], Q}.
- Shift-accumulate engine:
  - On load: latches |m|, |q| as WIDTH-bit unsigned values, plus sign = m[MSB] XOR q[MSB]. |-2^31| = 2^31 unsigned.
  - Each iteration: if the current multiplier LSB is 1, add the multiplicand shifted into a 2*WIDTH accumulator; then shift.
  - On completion, product = sign ? -acc : acc.
- Tree:
  - Purely combinational from the current m/q; no clock dependence.
  - Builds sign-correct partial products (Baugh-Wooley or sign-extended rows) reduced by an adder tree.
  - Exact for all 2^64 input pairs.
- All products are exact signed 64-bit results; no overflow is possible, including (-2^31)*(-2^31) = 2^62.
- products_match is combinational: done AND (booth_product == shift_product) AND (shift_product == tree_product). It is meaningful only while m/q are held stable.

Decomposition:
- Package multiplier_pkg holds:
  - WIDTH
  - PROD_W = 2*WIDTH
  - CNT_W = clog2(WIDTH)
  - state enum {IDLE, RUN, DONE}
- One natural sub-module, tree_mult_comb: the combinational partial-product tree.
- The two sequential engines stay as separate always-blocks (or small FSMs) inside the top.

Test Plan:
- Reset, then 12345 x 6789 with start pulsed one cycle:
  - done rises exactly 32 cycles after the start edge.
  - All three products = 83810205; products_match = 1.
- Sign combinations:
  - -12345 x 6789 -> -83810205.
  - -12345 x -6789 -> 83810205.
  - 12345678 x -87654321 and the mirrored-sign case -> -1082152022374638 on all outputs.
- Extremes:
  - 0 x 123456789 -> 0.
  - 2147483647^2 -> 4611686014132420609.
  - (-2^31)^2 -> 4611686018427387904.
  - 2147483647 x -2^31 -> -4611686016279904256.
  - 2147483647 x -1 -> -2147483647.
  - -2^31 x 1 -> -2147483648.
- Back-to-back operations:
  - 987654321 x 123456789 -> 121932631112635269.
  - The next start clears done in the start cycle, so no stale result is visible with done=1.
- Restart and reset:
  - start re-pulsed 10 cycles into RUN with new operands -> done arrives 32 cycles after the second start, with the second product.
  - rst at cycle 15 of RUN -> products 0, done 0, no completion afterwards.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared constants, engine state type and helpers for the multiplier_trio block.
//   WIDTH  : operand width (two's complement)
//   PROD_W : product width
//   CNT_W  : iteration counter width
package multiplier_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH);

  // Common state encoding for both sequential engines.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Magnitude of a two's complement operand as an unsigned WIDTH-bit value.
  // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/multiplier_trio_if.sv
// Operand/result bundle for multiplier_trio.
//   master : drives start, m, q; observes products and status
//   slave  : the multiplier block itself
interface multiplier_trio_if;
  import multiplier_pkg::*;

  logic              start;
  logic [WIDTH-1:0]  m;
  logic [WIDTH-1:0]  q;
  logic [PROD_W-1:0] booth_product;
  logic [PROD_W-1:0] shift_product;
  logic [PROD_W-1:0] tree_product;
  logic              booth_done;
  logic              shift_done;
  logic              done;
  logic              products_match;

  modport master (
    output start, m, q,
    input  booth_product, shift_product, tree_product,
    input  booth_done, shift_done, done, products_match
  );

  modport slave (
    input  start, m, q,
    output booth_product, shift_product, tree_product,
    output booth_done, shift_done, done, products_match
  );

endinterface

// File: rtl/multiplier_trio_tree_mult_comb.sv
// Combinational signed OP_W x OP_W multiplier built from sign-extended partial
// products summed by a balanced adder tree.
//   i_m       : signed multiplicand
//   i_q       : signed multiplier
//   o_product : signed 2*OP_W product
module tree_mult_comb #(
  parameter int unsigned OP_W = multiplier_pkg::WIDTH
) (
  input  logic [OP_W-1:0]   i_m,
  input  logic [OP_W-1:0]   i_q,
  output logic [2*OP_W-1:0] o_product
);

  localparam int unsigned PW    = 2 * OP_W;
  // Leaves 0..OP_W-1 are partial products; node OP_W+k sums nodes 2k and 2k+1,
  // so the last node is the root of the tree.
  localparam int unsigned NODES = 2 * OP_W - 1;

  logic [PW-1:0] w_m_ext;
  logic [PW-1:0] w_node [NODES];

  assign w_m_ext = {{OP_W{i_m[OP_W-1]}}, i_m};

  always_comb begin
    for (int i = 0; i < int'(NODES); i++) begin
      w_node[i] = '0;
    end
    for (int i = 0; i < int'(OP_W); i++) begin
      if (i_q[i]) begin
        w_node[i] = w_m_ext << i;
      end
    end
    // The multiplier MSB carries weight -2^(OP_W-1), so its row is subtracted.
    if (i_q[OP_W-1]) begin
      w_node[OP_W-1] = -(w_m_ext << (OP_W - 1));
    end
    for (int k = 0; k < int'(OP_W) - 1; k++) begin
      w_node[int'(OP_W) + k] = w_node[2*k] + w_node[2*k+1];
    end
  end

  assign o_product = w_node[NODES-1];

endmodule

// File: rtl/multiplier_trio.sv
// Signed WIDTH x WIDTH multiplier with three implementations that can be
// cross-checked: radix-2 Booth (sequential), shift-accumulate on magnitudes
// (sequential) and a combinational partial-product tree.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, priority over start
//   bus : multiplier_trio_if slave (start/m/q in; products, done flags, match out)
// Each sequential engine runs IDLE -> RUN -> DONE; RUN spans WIDTH edges and a
// start in any state restarts the engine with fresh operands.
module multiplier_trio
  import multiplier_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  multiplier_trio_if.slave   bus
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // Booth engine
  // ---------------------------------------------------------------------------
  state_e            r_booth_state;
  state_e            w_booth_state_nxt;
  logic [WIDTH:0]    r_b_a;    // one guard bit so -M of the most negative M is exact
  logic [WIDTH:0]    r_b_m;
  logic [WIDTH-1:0]  r_b_q;
  logic              r_b_qm1;
  logic [CNT_W-1:0]  r_b_cnt;
  logic [PROD_W-1:0] r_booth_product;

  logic [WIDTH:0]    w_b_sum;
  logic [WIDTH:0]    w_b_a_nxt;
  logic [WIDTH-1:0]  w_b_q_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_booth_state <= IDLE;
    end else begin
      r_booth_state <= w_booth_state_nxt;
    end
  end

  always_comb begin
    w_booth_state_nxt = r_booth_state;
    case (r_booth_state)
      IDLE:    w_booth_state_nxt = IDLE;
      RUN:     if (r_b_cnt == LastCnt) w_booth_state_nxt = DONE;
      DONE:    w_booth_state_nxt = DONE;
      default: w_booth_state_nxt = IDLE;
    endcase
    if (bus.start) begin
      w_booth_state_nxt = RUN;
    end
  end

  always_comb begin
    bus.booth_done = (r_booth_state == DONE);
  end

  always_comb begin
    w_b_sum = r_b_a;
    case ({r_b_q[0], r_b_qm1})
      2'b01:   w_b_sum = r_b_a + r_b_m;
      2'b10:   w_b_sum = r_b_a - r_b_m;
      default: w_b_sum = r_b_a;
    endcase
    // Arithmetic right shift of {A, Q, Q_-1}.
    w_b_a_nxt = {w_b_sum[WIDTH], w_b_sum[WIDTH:1]};
    w_b_q_nxt = {w_b_sum[0], r_b_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_a           <= '0;
      r_b_m           <= '0;
      r_b_q           <= '0;
      r_b_qm1         <= 1'b0;
      r_b_cnt         <= '0;
      r_booth_product <= '0;
    end else if (bus.start) begin
      r_b_a   <= '0;
      r_b_m   <= {bus.m[WIDTH-1], bus.m};
      r_b_q   <= bus.q;
      r_b_qm1 <= 1'b0;
      r_b_cnt <= '0;
    end else if (r_booth_state == RUN) begin
      r_b_a   <= w_b_a_nxt;
      r_b_q   <= w_b_q_nxt;
      r_b_qm1 <= r_b_q[0];
      r_b_cnt <= r_b_cnt + CNT_W'(1);
      if (r_b_cnt == LastCnt) begin
        r_booth_product <= {w_b_a_nxt[WIDTH-1:0], w_b_q_nxt};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-accumulate engine (unsigned magnitudes, sign applied at the end)
  // ---------------------------------------------------------------------------
  state_e            r_shift_state;
  state_e            w_shift_state_nxt;
  logic [PROD_W-1:0] r_s_mcand;
  logic [WIDTH-1:0]  r_s_mplier;
  logic [PROD_W-1:0] r_s_acc;
  logic              r_s_sign;
  logic [CNT_W-1:0]  r_s_cnt;
  logic [PROD_W-1:0] r_shift_product;

  logic [PROD_W-1:0] w_s_acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift_state <= IDLE;
    end else begin
      r_shift_state <= w_shift_state_nxt;
    end
  end

  always_comb begin
    w_shift_state_nxt = r_shift_state;
    case (r_shift_state)
      IDLE:    w_shift_state_nxt = IDLE;
      RUN:     if (r_s_cnt == LastCnt) w_shift_state_nxt = DONE;
      DONE:    w_shift_state_nxt = DONE;
      default: w_shift_state_nxt = IDLE;
    endcase
    if (bus.start) begin
      w_shift_state_nxt = RUN;
    end
  end

  always_comb begin
    bus.shift_done = (r_shift_state == DONE);
  end

  always_comb begin
    w_s_acc_nxt = r_s_mplier[0] ? (r_s_acc + r_s_mcand) : r_s_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_mcand       <= '0;
      r_s_mplier      <= '0;
      r_s_acc         <= '0;
      r_s_sign        <= 1'b0;
      r_s_cnt         <= '0;
      r_shift_product <= '0;
    end else if (bus.start) begin
      r_s_mcand  <= {{WIDTH{1'b0}}, abs_val(bus.m)};
      r_s_mplier <= abs_val(bus.q);
      r_s_acc    <= '0;
      r_s_sign   <= bus.m[WIDTH-1] ^ bus.q[WIDTH-1];
      r_s_cnt    <= '0;
    end else if (r_shift_state == RUN) begin
      r_s_acc    <= w_s_acc_nxt;
      r_s_mcand  <= r_s_mcand << 1;
      r_s_mplier <= r_s_mplier >> 1;
      r_s_cnt    <= r_s_cnt + CNT_W'(1);
      if (r_s_cnt == LastCnt) begin
        r_shift_product <= r_s_sign ? -w_s_acc_nxt : w_s_acc_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational tree and outputs
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] w_tree_product;

  tree_mult_comb #(
    .OP_W (WIDTH)
  ) u_tree (
    .i_m       (bus.m),
    .i_q       (bus.q),
    .o_product (w_tree_product)
  );

  assign bus.booth_product  = r_booth_product;
  assign bus.shift_product  = r_shift_product;
  assign bus.tree_product   = w_tree_product;
  assign bus.done           = bus.booth_done & bus.shift_done;
  assign bus.products_match = bus.done
                              & (r_booth_product == r_shift_product)
                              & (r_shift_product == w_tree_product);

endmodule

// File: tb/tb_multiplier_trio.sv
module tb_multiplier_trio;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  multiplier_trio_if u_if();

  multiplier_trio u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] p;
    string              name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Cycles from the start edge until done is seen high; -1 if the bound expires.
  task automatic wait_done(input int max_cyc, output int lat);
    lat = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      if (u_if.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_start(input logic signed [31:0] a, input logic signed [31:0] b);
    @(negedge clk);
    u_if.m     = a;
    u_if.q     = b;
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    pulse_start(v.a, v.b);
    chk({v.name, " done low after start"}, 64'(u_if.done), 64'sd0);
    wait_done(40, lat);
    chk({v.name, " latency"}, 64'(lat), 64'sd32);
    chk({v.name, " booth"}, u_if.booth_product, v.p);
    chk({v.name, " shift"}, u_if.shift_product, v.p);
    chk({v.name, " tree"}, u_if.tree_product, v.p);
    chk({v.name, " match"}, 64'(u_if.products_match), 64'sd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int rises;
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{32'sd12345,       32'sd6789,       64'sd83810205,             "pos_pos"};
    vecs[1]  = '{-32'sd12345,      32'sd6789,       -64'sd83810205,            "neg_pos"};
    vecs[2]  = '{-32'sd12345,      -32'sd6789,      64'sd83810205,             "neg_neg"};
    vecs[3]  = '{32'sd12345678,    -32'sd87654321,  -64'sd1082152022374638,    "big_pn"};
    vecs[4]  = '{-32'sd12345678,   32'sd87654321,   -64'sd1082152022374638,    "big_np"};
    vecs[5]  = '{32'sd0,           32'sd123456789,  64'sd0,                    "zero"};
    vecs[6]  = '{32'sd2147483647,  32'sd2147483647, 64'sd4611686014132420609,  "max_sq"};
    vecs[7]  = '{32'sh80000000,    32'sh80000000,   64'sd4611686018427387904,  "min_sq"};
    vecs[8]  = '{32'sd2147483647,  32'sh80000000,   -64'sd4611686016279904256, "max_min"};
    vecs[9]  = '{32'sd2147483647,  -32'sd1,         -64'sd2147483647,          "max_m1"};
    vecs[10] = '{32'sh80000000,    32'sd1,          -64'sd2147483648,          "min_one"};
    vecs[11] = '{32'sd987654321,   32'sd123456789,  64'sd121932631112635269,   "b2b"};

    // Reset held together with start: reset must win and nothing may run.
    rst        = 1'b1;
    u_if.start = 1'b1;
    u_if.m     = 32'sd7;
    u_if.q     = 32'sd9;
    repeat (3) @(posedge clk);
    #1;
    rst        = 1'b0;
    u_if.start = 1'b0;
    chk("reset booth_product", u_if.booth_product, 64'sd0);
    chk("reset shift_product", u_if.shift_product, 64'sd0);
    chk("reset booth_done", 64'(u_if.booth_done), 64'sd0);
    chk("reset shift_done", 64'(u_if.shift_done), 64'sd0);
    chk("reset match", 64'(u_if.products_match), 64'sd0);
    wait_done(35, lat);
    chk("rst beats start", 64'(lat), -64'sd1);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // DONE holds its result while operands change; tree follows the operands.
    @(negedge clk);
    u_if.m = 32'sd5;
    u_if.q = 32'sd7;
    repeat (3) @(posedge clk);
    #1;
    chk("hold booth", u_if.booth_product, 64'sd121932631112635269);
    chk("hold shift", u_if.shift_product, 64'sd121932631112635269);
    chk("hold done", 64'(u_if.done), 64'sd1);
    chk("hold tree follows", u_if.tree_product, 64'sd35);
    chk("hold match drops", 64'(u_if.products_match), 64'sd0);

    // Restart 10 cycles into RUN with new operands.
    pulse_start(32'sd111, 32'sd222);
    repeat (9) @(posedge clk);
    pulse_start(-32'sd1000, 32'sd3000);
    chk("restart done low", 64'(u_if.done), 64'sd0);
    wait_done(40, lat);
    chk("restart latency", 64'(lat), 64'sd32);
    chk("restart booth", u_if.booth_product, -64'sd3000000);
    chk("restart shift", u_if.shift_product, -64'sd3000000);
    chk("restart tree", u_if.tree_product, -64'sd3000000);
    chk("restart match", 64'(u_if.products_match), 64'sd1);

    // Reset 15 cycles into RUN: results cleared, no completion afterwards.
    pulse_start(32'sd4321, -32'sd1234);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst booth", u_if.booth_product, 64'sd0);
    chk("midrst shift", u_if.shift_product, 64'sd0);
    chk("midrst done", 64'(u_if.done), 64'sd0);
    rises = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (u_if.booth_done || u_if.shift_done) rises++;
    end
    chk("midrst no completion", 64'(rises), 64'sd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
